zxuno_regport: RTL and testbench

Parametrised successor of the ZX-UNO register address/data port pair. Decodes the Z80 I/O address port and the Z80 I/O data port, and holds the register address pointer, AW bits wide. Produces level and single-pulse read/write strobes toward the register file, and optionally auto-increments the pointer after each data-port access. Sits between the Z80 bus and every ZX-UNO register consumer.

---
 rtl/zxuno_regport_if.sv | 31 +++
 rtl/zxuno_regport.sv | 103 ++++++++++
 tb/tb_zxuno_regport.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/zxuno_regport_if.sv
// Z80-side bus bundle for the ZX-UNO register address/data port pair.
interface zxuno_regport_if #(
    parameter int AW = 8
);
    logic [15:0]   a;
    logic          iorq_n;
    logic          rd_n;
    logic          wr_n;
    logic [7:0]    din;
    logic          autoinc;
    logic [7:0]    dout;
    logic          oe;
    logic [AW-1:0] addr;
    logic          read_from_reg;
    logic          write_to_reg;
    logic          rd_stb;
    logic          wr_stb;
    logic          regaddr_changed;

    modport master (
        output a, iorq_n, rd_n, wr_n, din, autoinc,
        input  dout, oe, addr, read_from_reg, write_to_reg,
        input  rd_stb, wr_stb, regaddr_changed
    );

    modport slave (
        input  a, iorq_n, rd_n, wr_n, din, autoinc,
        output dout, oe, addr, read_from_reg, write_to_reg,
        output rd_stb, wr_stb, regaddr_changed
    );
endinterface

// File: rtl/zxuno_regport.sv
// ZX-UNO register address/data port pair: pointer register, decode, and
// one-pulse-per-I/O-cycle strobes with optional pointer auto-increment.
module zxuno_regport #(
    parameter logic [15:0] IOADDR  = 16'hFC3B,
    parameter logic [15:0] IODATA  = 16'hFD3B,
    parameter int          AW      = 8,
    parameter int unsigned RSTADDR = 0
) (
    input  logic           clk,
    input  logic           rst,
    zxuno_regport_if.slave bus
);
    typedef enum logic [1:0] {SETTLE, IDLE, ACCESS} state_t;

    state_t        r_state;
    logic [AW-1:0] r_addr;
    logic          r_rd_stb;
    logic          r_wr_stb;
    logic          r_changed;
    logic          r_kind_data;
    logic          r_autoinc;

    logic          w_rw;
    logic          w_hit_a;
    logic          w_hit_d;
    logic          w_acc_a;
    logic          w_acc_d;
    logic          w_write;
    logic          w_oe;
    logic [7:0]    w_dout;

    assign w_rw    = !bus.rd_n || !bus.wr_n;
    assign w_hit_a = !bus.iorq_n && (bus.a == IOADDR);
    assign w_hit_d = !bus.iorq_n && (bus.a == IODATA);
    assign w_acc_a = w_hit_a && w_rw;
    assign w_acc_d = w_hit_d && w_rw;
    assign w_write = !bus.wr_n;
    assign w_oe    = w_hit_a && !bus.rd_n && bus.wr_n;

    always_comb begin
        w_dout = 8'h00;
        if (w_oe)
            w_dout[AW-1:0] = r_addr;
    end

    assign bus.oe              = w_oe;
    assign bus.dout            = w_dout;
    assign bus.addr            = r_addr;
    assign bus.read_from_reg   = w_hit_d && !bus.rd_n && bus.wr_n;
    assign bus.write_to_reg    = w_hit_d && !bus.wr_n;
    assign bus.rd_stb          = r_rd_stb;
    assign bus.wr_stb          = r_wr_stb;
    assign bus.regaddr_changed = r_changed;

    // SETTLE swallows any I/O cycle already in flight when reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= SETTLE;
            r_addr      <= AW'(RSTADDR);
            r_rd_stb    <= 1'b0;
            r_wr_stb    <= 1'b0;
            r_changed   <= 1'b1;
            r_kind_data <= 1'b0;
            r_autoinc   <= 1'b0;
        end else begin
            r_rd_stb  <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_changed <= 1'b0;
            case (r_state)
                SETTLE: begin
                    if (bus.iorq_n)
                        r_state <= IDLE;
                end
                IDLE: begin
                    if (w_acc_a || w_acc_d) begin
                        r_state     <= ACCESS;
                        r_kind_data <= w_acc_d;
                        r_autoinc   <= bus.autoinc;
                        if (w_acc_a && w_write) begin
                            r_addr    <= bus.din[AW-1:0];
                            r_changed <= 1'b1;
                        end
                        if (w_acc_d) begin
                            r_wr_stb <= w_write;
                            r_rd_stb <= !w_write;
                        end
                    end
                end
                ACCESS: begin
                    // Increment only once the Z80 has finished the cycle.
                    if (bus.iorq_n) begin
                        r_state <= IDLE;
                        if (r_kind_data && r_autoinc) begin
                            r_addr    <= r_addr + AW'(1);
                            r_changed <= 1'b1;
                        end
                    end
                end
                default: r_state <= SETTLE;
            endcase
        end
    end
endmodule

// File: tb/tb_zxuno_regport.sv
// Directed bench for zxuno_regport: one AW=8 and one AW=4 instance on a shared bus.
module tb_zxuno_regport;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a;
    logic        iorq_n, rd_n, wr_n, autoinc;
    logic [7:0]  din;

    int n_cmp = 0;
    int n_err = 0;
    int wr8 = 0, rd8 = 0, chg8 = 0, lvl8 = 0, rd4 = 0;
    int s_wr8, s_rd8, s_chg8, s_lvl8, s_rd4;

    zxuno_regport_if #(.AW(8)) b8 ();
    zxuno_regport_if #(.AW(4)) b4 ();

    assign b8.a = a;  assign b8.iorq_n = iorq_n; assign b8.rd_n = rd_n;
    assign b8.wr_n = wr_n; assign b8.din = din; assign b8.autoinc = autoinc;
    assign b4.a = a;  assign b4.iorq_n = iorq_n; assign b4.rd_n = rd_n;
    assign b4.wr_n = wr_n; assign b4.din = din; assign b4.autoinc = autoinc;

    zxuno_regport #(.AW(8), .RSTADDR(0)) u_dut8 (.clk(clk), .rst(rst), .bus(b8));
    zxuno_regport #(.AW(4), .RSTADDR(0)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (b8.wr_stb)          wr8++;
        if (b8.rd_stb)          rd8++;
        if (b8.regaddr_changed) chg8++;
        if (b8.write_to_reg)    lvl8++;
        if (b4.rd_stb)          rd4++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        s_wr8 = wr8; s_rd8 = rd8; s_chg8 = chg8; s_lvl8 = lvl8; s_rd4 = rd4;
    endtask

    task automatic cyc_begin(input logic [15:0] ad, input logic rdn, input logic wrn,
                             input logic [7:0] d, input logic ai);
        @(negedge clk);
        a = ad; rd_n = rdn; wr_n = wrn; din = d; autoinc = ai; iorq_n = 1'b0;
        #1;
    endtask

    task automatic cyc_end(input int n);
        repeat (n) @(negedge clk);
        iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; a = 16'h0000; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        din = 8'h00; autoinc = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_addr", b8.addr, 8'h00);
        check("rst_chg", b8.regaddr_changed, 1'b1);
        check("rst_stb", {b8.rd_stb, b8.wr_stb}, 2'b00);
        check("rst_oe_dout", {b8.oe, b8.dout}, 9'h000);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("settle_chg_clr", b8.regaddr_changed, 1'b0);

        // Address-port write, held 4 clks.
        snap();
        cyc_begin(16'hFC3B, 1'b1, 1'b0, 8'h42, 1'b0);
        @(negedge clk); #1;
        check("aw_addr_1clk", b8.addr, 8'h42);
        check("aw_chg_high", b8.regaddr_changed, 1'b1);
        cyc_end(3);
        check("aw_chg_once", chg8 - s_chg8, 1);
        check("aw_no_wrstb", wr8 - s_wr8, 0);

        // Address-port read-back.
        cyc_begin(16'hFC3B, 1'b0, 1'b1, 8'h00, 1'b0);
        check("ar_oe", b8.oe, 1'b1);
        check("ar_dout", b8.dout, 8'h42);
        cyc_end(2);
        check("ar_oe_after", b8.oe, 1'b0);
        check("ar_dout_after", b8.dout, 8'h00);

        // Auto-increment data writes of 3, 6 and 2 clks from FE.
        cyc_begin(16'hFC3B, 1'b1, 1'b0, 8'hFE, 1'b0);
        cyc_end(2);
        check("ai_start", b8.addr, 8'hFE);
        snap();
        cyc_begin(16'hFD3B, 1'b1, 1'b0, 8'h11, 1'b1);
        check("ai_wlvl_on", b8.write_to_reg, 1'b1);
        cyc_end(3);
        check("ai_addr1", b8.addr, 8'hFF);
        check("ai_lvl1", lvl8 - s_lvl8, 3);
        check("ai_wlvl_off", b8.write_to_reg, 1'b0);
        snap();
        cyc_begin(16'hFD3B, 1'b1, 1'b0, 8'h22, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        check("ai_addr_mid", b8.addr, 8'hFF);
        cyc_end(3);
        check("ai_addr2", b8.addr, 8'h00);
        check("ai_lvl2", lvl8 - s_lvl8, 6);
        check("ai_wr2", wr8 - s_wr8, 1);
        check("ai_chg2", chg8 - s_chg8, 1);
        snap();
        cyc_begin(16'hFD3B, 1'b1, 1'b0, 8'h33, 1'b1);
        cyc_end(2);
        check("ai_addr3", b8.addr, 8'h01);
        check("ai_lvl3", lvl8 - s_lvl8, 2);
        check("ai_wr3", wr8 - s_wr8, 1);

        // Narrow pointer: upper din bits dropped, read-back zero-extended, wrap at 4'hF.
        cyc_begin(16'hFC3B, 1'b1, 1'b0, 8'hA7, 1'b0);
        cyc_end(2);
        check("aw4_addr", b4.addr, 4'h7);
        cyc_begin(16'hFC3B, 1'b0, 1'b1, 8'h00, 1'b0);
        check("aw4_dout", b4.dout, 8'h07);
        cyc_end(2);
        cyc_begin(16'hFC3B, 1'b1, 1'b0, 8'h0F, 1'b0);
        cyc_end(2);
        snap();
        cyc_begin(16'hFD3B, 1'b0, 1'b1, 8'h00, 1'b1);
        check("aw4_rlvl", b4.read_from_reg, 1'b1);
        cyc_end(4);
        check("aw4_rdstb", rd4 - s_rd4, 1);
        check("aw4_wrap", b4.addr, 4'h0);
        check("aw8_inc", b8.addr, 8'h10);

        // rd_n and wr_n both low: write wins.
        snap();
        cyc_begin(16'hFD3B, 1'b0, 1'b0, 8'h55, 1'b0);
        check("both_rlvl", b8.read_from_reg, 1'b0);
        check("both_wlvl", b8.write_to_reg, 1'b1);
        cyc_end(3);
        check("both_wr", wr8 - s_wr8, 1);
        check("both_rd", rd8 - s_rd8, 0);
        check("both_addr", b8.addr, 8'h10);

        // Reset released while a data-port access is in flight.
        @(negedge clk); rst = 1'b1;
        cyc_begin(16'hFD3B, 1'b1, 1'b0, 8'h66, 1'b1);
        @(negedge clk); rst = 1'b0;
        snap();
        cyc_end(3);
        check("rel_wr", wr8 - s_wr8, 0);
        check("rel_rd", rd8 - s_rd8, 0);
        check("rel_addr", b8.addr, 8'h00);
        snap();
        cyc_begin(16'hFD3B, 1'b1, 1'b0, 8'h77, 1'b0);
        cyc_end(2);
        check("rel_next_wr", wr8 - s_wr8, 1);

        // Reset asserted mid-access with auto-increment latched.
        cyc_begin(16'hFC3B, 1'b1, 1'b0, 8'h05, 1'b0);
        cyc_end(2);
        check("mid_pre", b8.addr, 8'h05);
        cyc_begin(16'hFD3B, 1'b1, 1'b0, 8'h88, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_async_addr", b8.addr, 8'h00);
        check("mid_async_chg", b8.regaddr_changed, 1'b1);
        @(negedge clk);
        iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("mid_no_inc", b8.addr, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
